// File: rtl/alu_ctrl_pkg.sv
// ALU control definitions shared by the EX-stage ALU decoder and the multiply sequencer.
//   - 4-bit ALU control codes
//   - state encoding for the multi-cycle multiply sequencer
package alu_ctrl_pkg;

   localparam logic [3:0] AluAnd  = 4'd0;
   localparam logic [3:0] AluOr   = 4'd1;
   localparam logic [3:0] AluAdd  = 4'd2;
   localparam logic [3:0] AluSub  = 4'd6;
   localparam logic [3:0] AluSlt  = 4'd7;
   localparam logic [3:0] AluMult = 4'd11;
   localparam logic [3:0] AluBne  = 4'd12;
   localparam logic [3:0] AluBge  = 4'd13;
   localparam logic [3:0] AluBgt  = 4'd14;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } mult_state_e;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiplier datapath: unsigned magnitudes are multiplied one bit per step,
// with the sign applied once at the end.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-low reset, clears product and multiplicand
//   load_i      latch |src1_i| as multiplicand and |src2_i| into the low product half
//   step_i      one shift-add iteration
//   finalize_i  present the signed product on prod_o
//   neg_i       product sign (only used while finalize_i is high)
//   src1_i      operand A, two's complement
//   src2_i      operand B, two's complement
//   prod_o      2*WIDTH product
module mult_shift_add_dp #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic                 finalize_i,
   input  logic                 neg_i,
   input  logic [WIDTH-1:0]     src1_i,
   input  logic [WIDTH-1:0]     src2_i,
   output logic [2*WIDTH-1:0]   prod_o
);

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;

   // The most negative value maps to 2^(WIDTH-1), which still fits as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + One) : v;
   endfunction

   always_comb begin
      prod_d  = prod_q;
      mcand_d = mcand_q;
      addend  = prod_q[0] ? mcand_q : '0;
      // Extra bit keeps the carry so it can shift into the product MSB.
      sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      if (load_i) begin
         mcand_d = mag(src1_i);
         prod_d  = {{WIDTH{1'b0}}, mag(src2_i)};
      end else if (step_i) begin
         prod_d = {sum, prod_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         prod_q  <= '0;
         mcand_q <= '0;
      end else begin
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
      end
   end

   assign prod_o = (finalize_i && neg_i) ? (~prod_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// EX-stage sequencer for the MULT ALU operation. Stalls the pipeline while the
// shift-add datapath iterates, then writes the signed product to HI/LO and pulses done_o.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-low reset
//   valid_i     EX instruction valid
//   alu_ctrl_i  ALU control code of the EX instruction
//   src1_i      operand A (rs)
//   src2_i      operand B (rt)
//   flush_i     squash the EX instruction
//   stall_o     hold PC, IF/ID and ID/EX
//   done_o      one-cycle pulse, HI/LO update at the end of this cycle
//   hi_o, lo_o  last completed product
//   result_o    LO, forwarded to EX/MEM write data
module mult_seq_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter logic [3:0]  MULT_CTRL = AluMult
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [3:0]       alu_ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   mult_state_e        state_q;
   logic [CntW-1:0]    cnt_q;
   logic               neg_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               start;
   logic               load;
   logic               step;
   logic               in_busy;
   logic               in_done;
   logic [2*WIDTH-1:0] prod;

   assign start   = valid_i & (alu_ctrl_i == MULT_CTRL) & ~flush_i;
   assign load    = (state_q == StIdle) & start;
   assign in_busy = (state_q == StBusy);
   assign in_done = (state_q == StDone);
   assign step    = in_busy & ~flush_i;

   mult_shift_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load),
      .step_i     (step),
      .finalize_i (in_done),
      .neg_i      (neg_q),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .prod_o     (prod)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StBusy;
                  cnt_q   <= '0;
                  neg_q   <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
               end
            end
            StBusy: begin
               if (flush_i) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntOne;
                  if (cnt_q == CntLast) state_q <= StDone;
               end
            end
            StDone: begin
               // The released MULT is still on the inputs; IDLE only resamples next cycle.
               hi_q    <= prod[2*WIDTH-1:WIDTH];
               lo_q    <= prod[WIDTH-1:0];
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Combinational so the pipeline freezes in the same cycle the MULT is seen.
   assign stall_o  = load | in_busy;
   assign done_o   = in_done;
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;
   assign result_o = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic [3:0]  ctrl = 4'd0;
   logic [31:0] s1 = '0;
   logic [31:0] s2 = '0;
   logic        flush = 1'b0;
   logic        stall_o, done_o;
   logic [31:0] hi_o, lo_o, result_o;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   logic [63:0] exp_q[$];

   mult_seq_ctrl #(
      .WIDTH     (32),
      .MULT_CTRL (4'd11)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (valid),
      .alu_ctrl_i (ctrl),
      .src1_i     (s1),
      .src2_i     (s2),
      .flush_i    (flush),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue a MULT and hold it until done_o; leaves inputs unchanged on return.
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, output int done_cyc);
      int cyc;
      int stall_cnt;
      @(negedge clk);
      valid = 1'b1; ctrl = 4'd11; s1 = a; s2 = b; flush = 1'b0;
      exp_q.push_back(exp);
      #1;
      check("stall_at_start", {63'd0, stall_o}, 64'd1);
      stall_cnt = stall_o ? 1 : 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         #1;
         if (done_o || cyc >= 100) break;
         if (stall_o) stall_cnt++;
      end
      done_cyc = cyc_cnt;
      check("done_latency", 64'(cyc), 64'd33);
      check("stall_cycles", 64'(stall_cnt), 64'd33);
      check("stall_in_done", {63'd0, stall_o}, 64'd0);
   endtask

   task automatic go_idle();
      @(negedge clk);
      valid = 1'b0; ctrl = 4'd0; flush = 1'b0;
   endtask

   // Monitor: HI/LO are valid from the edge that ends the done_o cycle.
   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (done_o) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got hi=%h lo=%h expected no done_o", hi_o, lo_o);
            end else begin
               e = exp_q.pop_front();
               check("product", {hi_o, lo_o}, e);
               check("result_eq_lo", {32'd0, result_o}, {32'd0, e[31:0]});
            end
         end
      end
   end

   initial begin : stim
      int t1, t2, cyc;
      logic any_done;
      logic [3:0] codes [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall", {63'd0, stall_o}, 64'd0);
      check("reset_done", {63'd0, done_o}, 64'd0);
      check("reset_hilo", {hi_o, lo_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed products
      run_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F, t1);
      go_idle();
      run_mult(32'hFFFF_FFFE, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, t1);
      go_idle();
      run_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, t1);
      go_idle();
      run_mult(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, t1);
      go_idle();
      run_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, t1);
      go_idle();
      run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, t1);
      go_idle();
      run_mult(32'd12345, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7, t1);
      go_idle();
      run_mult(32'd0, 32'hDEAD_BEEF, 64'h0, t1);
      go_idle();
      run_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F, t1);
      go_idle();

      // Flush in BUSY cycle 10
      @(negedge clk);
      valid = 1'b1; ctrl = 4'd11; s1 = 32'd100; s2 = 32'd200;
      for (int i = 1; i <= 10; i++) @(negedge clk);
      flush = 1'b1;
      #1;
      check("stall_busy_flush_cycle", {63'd0, stall_o}, 64'd1);
      @(negedge clk);
      flush = 1'b0; valid = 1'b0; ctrl = 4'd0;
      #1;
      check("stall_after_flush", {63'd0, stall_o}, 64'd0);
      any_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (done_o || stall_o) any_done = 1'b1;
      end
      check("no_done_after_flush", {63'd0, any_done}, 64'd0);
      check("hilo_kept_after_flush", {hi_o, lo_o}, 64'd15);

      // Non-MULT codes and an invalid MULT never start
      any_done = 1'b0;
      foreach (codes[k]) begin
         @(negedge clk);
         valid = 1'b1; ctrl = codes[k]; s1 = 32'd9; s2 = 32'd9;
         #1;
         check("stall_non_mult", {63'd0, stall_o}, 64'd0);
      end
      @(negedge clk);
      valid = 1'b0; ctrl = 4'd11;
      #1;
      check("stall_invalid_mult", {63'd0, stall_o}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (done_o || stall_o) any_done = 1'b1;
      end
      check("no_start_non_mult", {63'd0, any_done}, 64'd0);
      check("hilo_kept_non_mult", {hi_o, lo_o}, 64'd15);

      // Reset in BUSY cycle 5
      @(negedge clk);
      valid = 1'b1; ctrl = 4'd11; s1 = 32'd7; s2 = 32'd7;
      for (int i = 1; i <= 5; i++) @(negedge clk);
      #1;
      check("stall_before_reset", {63'd0, stall_o}, 64'd1);
      rst = 1'b0;
      @(negedge clk);
      valid = 1'b0; ctrl = 4'd0;
      #1;
      check("stall_after_reset", {63'd0, stall_o}, 64'd0);
      check("hilo_after_reset", {hi_o, lo_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      any_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (done_o) any_done = 1'b1;
      end
      check("no_done_after_reset", {63'd0, any_done}, 64'd0);

      // Back-to-back MULTs: second restarts in the cycle after DONE
      run_mult(32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, t1);
      run_mult(32'd1000, 32'd1000, 64'h0000_0000_000F_4240, t2);
      go_idle();
      check("back_to_back_spacing", 64'(t2 - t1), 64'd34);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      cyc = cyc_cnt;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
